// File: rtl/prng_checker.sv
// prng_checker: receive-side checker for a 32-bit Fibonacci LFSR word stream.
// Self-synchronises by seeding a local LFSR from incoming data, then predicts
// every following word and keeps saturating error and word counters.
// Optional build macro: PRNG_CHECKER_BITERR_EN -- when defined, a mismatch in
// LOCKED adds the number of differing bits to err_cnt instead of 1.
//
// state    | meaning
// IDLE     | checker disabled, counters and prediction hold
// SEARCH   | waiting for a non-zero word to seed the local LFSR
// VERIFY   | seeded, counting consecutive matches toward lock
// LOCKED   | tracking; mismatches counted, LOSS_CNT in a row drop lock
module prng_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        enable,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        locked,
    output logic [15:0] err_cnt,
    output logic [15:0] word_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_VERIFY = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t      cur_state, nxt_state;
    logic [31:0] exp_q, exp_d;
    logic [3:0]  run_q, run_d;
    logic [15:0] err_d, word_d;
    logic        accept;
    logic        match;
    logic [3:0]  run_inc;
    logic [5:0]  err_add;
    logic [16:0] err_sum;
    logic [15:0] err_sat;
    logic [15:0] word_sat;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    assign in_ready = enable;
    assign accept   = in_valid & enable;
    assign match    = (in_data == exp_q);
    assign run_inc  = run_q + 4'd1;

`ifdef PRNG_CHECKER_BITERR_EN
    assign err_add = 6'($countones(in_data ^ exp_q));
`else
    assign err_add = 6'd1;
`endif

    assign err_sum  = {1'b0, err_cnt} + {11'd0, err_add};
    assign err_sat  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    assign word_sat = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;

    // Next-state, prediction and counter update; clr outranks everything but reset.
    always_comb begin
        nxt_state = cur_state;
        exp_d     = exp_q;
        run_d     = run_q;
        err_d     = err_cnt;
        word_d    = word_cnt;
        if (clr) begin
            err_d     = 16'd0;
            word_d    = 16'd0;
            run_d     = 4'd0;
            nxt_state = enable ? S_SEARCH : S_IDLE;
        end else if (!enable) begin
            nxt_state = S_IDLE;
        end else begin
            case (cur_state)
                S_IDLE: nxt_state = S_SEARCH;
                S_SEARCH: begin
                    if (accept && in_data != 32'd0) begin
                        exp_d     = lfsr_next(in_data);
                        run_d     = 4'd0;
                        nxt_state = S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (accept) begin
                        if (match) begin
                            exp_d = lfsr_next(exp_q);
                            if (run_inc == 4'(LOCK_CNT)) begin
                                run_d     = 4'd0;
                                nxt_state = S_LOCKED;
                            end else begin
                                run_d = run_inc;
                            end
                        end else if (in_data != 32'd0) begin
                            exp_d = lfsr_next(in_data);
                            run_d = 4'd0;
                        end else begin
                            run_d     = 4'd0;
                            nxt_state = S_SEARCH;
                        end
                    end
                end
                S_LOCKED: begin
                    if (accept) begin
                        // Prediction free-runs; an errored sample never reseeds it.
                        exp_d  = lfsr_next(exp_q);
                        word_d = word_sat;
                        if (match) begin
                            run_d = 4'd0;
                        end else begin
                            err_d = err_sat;
                            if (run_inc == 4'(LOSS_CNT)) begin
                                run_d     = 4'd0;
                                nxt_state = S_SEARCH;
                            end else begin
                                run_d = run_inc;
                            end
                        end
                    end
                end
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    // Register state, prediction, run counter and the registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cur_state <= S_IDLE;
            locked    <= 1'b0;
            err_cnt   <= 16'd0;
            word_cnt  <= 16'd0;
            exp_q     <= 32'd0;
            run_q     <= 4'd0;
        end else begin
            cur_state <= nxt_state;
            locked    <= (nxt_state == S_LOCKED);
            err_cnt   <= err_d;
            word_cnt  <= word_d;
            exp_q     <= exp_d;
            run_q     <= run_d;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_prng_checker.sv
// Directed testbench for prng_checker (default parameters LOCK_CNT=4, LOSS_CNT=8).
module tb_prng_checker;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        enable;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        locked;
    logic [15:0] err_cnt;
    logic [15:0] word_cnt;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;
    logic [31:0] g;

    prng_checker dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .enable   (enable),
        .clr      (clr),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .locked   (locked),
        .err_cnt  (err_cnt),
        .word_cnt (word_cnt),
        .state    (state)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [31:0] step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input int n);
        for (int i = 0; i < n; i++) begin
            send(g);
            g = step(g);
        end
    endtask

    initial begin
        wb_rst_i = 1'b1;
        enable   = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_word", 32'(word_cnt), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        wb_rst_i = 1'b0;

        enable = 1'b1;
        tick();
        chk("en_state", 32'(state), 32'd1);
        chk("en_ready", 32'(in_ready), 32'd1);

        // zero words are dropped in SEARCH
        send(32'd0);
        send(32'd0);
        send(32'd0);
        chk("zero_search", 32'(state), 32'd1);

        // hand-stepped sequence from seed 1: 1, 3, 6, D, 1B
        send(32'h1);
        chk("seed_verify", 32'(state), 32'd2);
        send(32'h3);
        send(32'h6);
        send(32'hD);
        chk("pre_lock", 32'(locked), 32'd0);
        send(32'h1B);
        chk("lock_5th", 32'(locked), 32'd1);
        chk("lock_state", 32'(state), 32'd3);
        chk("lock_word0", 32'(word_cnt), 32'd0);
        g = 32'h36;
        send_seq(10);
        chk("ten_word", 32'(word_cnt), 32'd10);
        chk("ten_err", 32'(err_cnt), 32'd0);

        // single corrupted word, two bits flipped
        send(g ^ 32'h5);
        g = step(g);
`ifdef PRNG_CHECKER_BITERR_EN
        chk("corrupt_err", 32'(err_cnt), 32'd2);
`else
        chk("corrupt_err", 32'(err_cnt), 32'd1);
`endif
        chk("corrupt_locked", 32'(locked), 32'd1);
        send_seq(3);
`ifdef PRNG_CHECKER_BITERR_EN
        chk("resume_err", 32'(err_cnt), 32'd2);
`else
        chk("resume_err", 32'(err_cnt), 32'd1);
`endif
        chk("resume_word", 32'(word_cnt), 32'd14);

        // clr with a valid, matching sample: cleared and sample discarded
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = g;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_state", 32'(state), 32'd1);
        chk("clr_err", 32'(err_cnt), 32'd0);
        chk("clr_word", 32'(word_cnt), 32'd0);
        chk("clr_locked", 32'(locked), 32'd0);

        // relock, then 8 consecutive bad words drop lock
        g = 32'h1;
        send_seq(5);
        chk("relock1", 32'(locked), 32'd1);
        for (int i = 0; i < 7; i++) send(32'hDEADBEEF);
        chk("loss_pre", 32'(locked), 32'd1);
        send(32'hDEADBEEF);
        chk("loss_locked", 32'(locked), 32'd0);
        chk("loss_state", 32'(state), 32'd1);
        chk("loss_word", 32'(word_cnt), 32'd8);
`ifndef PRNG_CHECKER_BITERR_EN
        chk("loss_err", 32'(err_cnt), 32'd8);
`endif
        g = 32'h1;
        send_seq(5);
        chk("relock2", 32'(locked), 32'd1);
`ifndef PRNG_CHECKER_BITERR_EN
        chk("relock2_err", 32'(err_cnt), 32'd8);
`endif

        // enable low with a sample in flight: IDLE, counters hold
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = g;
        tick();
        in_valid = 1'b0;
        chk("dis_state", 32'(state), 32'd0);
        chk("dis_locked", 32'(locked), 32'd0);
        chk("dis_word", 32'(word_cnt), 32'd8);
        chk("dis_ready", 32'(in_ready), 32'd0);
        enable = 1'b1;
        tick();
        chk("reen_state", 32'(state), 32'd1);

        // clear, relock, then drive both counters into saturation
        clr = 1'b1;
        tick();
        clr = 1'b0;
        g = 32'h1;
        send_seq(5);
        chk("relock3", 32'(locked), 32'd1);
        for (int i = 0; i < 9400; i++) begin
            for (int j = 0; j < 7; j++) begin
                send(g ^ 32'h1);
                g = step(g);
            end
            send_seq(1);
            if (i == 99) begin
                chk("mid_err", 32'(err_cnt), 32'd700);
                chk("mid_word", 32'(word_cnt), 32'd800);
            end
        end
        chk("sat_err", 32'(err_cnt), 32'hFFFF);
        chk("sat_word", 32'(word_cnt), 32'hFFFF);
        chk("sat_locked", 32'(locked), 32'd1);

        // reset mid-stream with a valid sample
        wb_rst_i = 1'b1;
        in_valid = 1'b1;
        in_data  = g;
        tick();
        in_valid = 1'b0;
        chk("mrst_state", 32'(state), 32'd0);
        chk("mrst_err", 32'(err_cnt), 32'd0);
        chk("mrst_word", 32'(word_cnt), 32'd0);
        chk("mrst_locked", 32'(locked), 32'd0);
        wb_rst_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
